serial_frame_receiver: RTL and testbench

Serial-to-parallel frame receiver that sits directly downstream of the team's serial shift register and consumes its SO bit stream. It hunts for a start bit, assembles DATA_W data bits LSB-first (the order a right-shifting register emits them), optionally checks even parity and checks the stop bit. It then presents the word on a registered parallel bus with a one-cycle valid strobe and error flags.

---
 rtl/serial_frame_receiver_if.sv | 23 ++
 rtl/serial_frame_receiver.sv | 93 +++++++++
 tb/tb_serial_frame_receiver.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_receiver_if.sv
// Bundle of the serial input line and the parallel result bus of serial_frame_receiver.
// The receiver takes the slave side; whoever drives SI and consumes the words takes master.
interface serial_frame_receiver_if #(
  parameter int DATA_W = 8
);
  logic              SI;
  logic              bit_en;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              parity_err;
  logic              framing_err;
  logic              busy;

  modport master (
    output SI, bit_en,
    input  data_out, valid, parity_err, framing_err, busy
  );

  modport slave (
    input  SI, bit_en,
    output data_out, valid, parity_err, framing_err, busy
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// Start/data/parity/stop frame receiver for an LSB-first serial stream sampled on bit_en.
// Delivers each word with a one-clock valid strobe plus parity and framing error flags.
module serial_frame_receiver #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  serial_frame_receiver_if.slave bus
);
  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              parity_err_q;
  logic              framing_err_q;
  logic              parity_bad;

  // Even parity over data plus the received parity bit must reduce to zero.
  assign parity_bad = PARITY_EN && (^{shreg, par_bit});

  // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (bus.bit_en) begin
      case (state)
        ST_IDLE:   if (!bus.SI) state_next = ST_DATA;
        ST_DATA:   if (cnt == LAST_BIT) state_next = PARITY_EN ? ST_PARITY : ST_STOP;
        ST_PARITY: state_next = ST_STOP;
        ST_STOP:   state_next = bus.SI ? ST_IDLE : ST_BREAK;
        ST_BREAK:  if (bus.SI) state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: the assembly register is reset too; a frame aborted by rst leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.bit_en) begin
        case (state)
          ST_IDLE: cnt <= '0;
          ST_DATA: begin
            shreg[cnt] <= bus.SI;
            if (cnt != LAST_BIT) cnt <= cnt + CNT_W'(1);
          end
          ST_PARITY: par_bit <= bus.SI;
          ST_STOP: begin
            data_q        <= shreg;
            valid_q       <= 1'b1;
            parity_err_q  <= parity_bad;
            framing_err_q <= !bus.SI;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data_out    = data_q;
  assign bus.valid       = valid_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.framing_err = framing_err_q;
  assign bus.busy        = (state != ST_IDLE);
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: a parity instance and a no-parity instance,
// expected words queued by the stimulus and popped by per-instance monitors on valid.
module tb_serial_frame_receiver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_frame_receiver_if #(.DATA_W(8)) if_a ();
  serial_frame_receiver_if #(.DATA_W(8)) if_b ();

  serial_frame_receiver #(.DATA_W(8), .PARITY_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  serial_frame_receiver #(.DATA_W(8), .PARITY_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   va_cyc[$];
  int   vb_cyc[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cyc_a = 0;
  exp_t ea, eb;
  logic prev_va = 1'b0;
  logic prev_vb = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (if_a.valid) begin
      check("a_valid_one_cycle", 32'(prev_va), 32'd0);
      if (qa.size() == 0) check("a_valid_expected", 32'(qa.size()), 32'd1);
      else begin
        ea = qa.pop_front();
        check("a_data_out", 32'(if_a.data_out), 32'(ea.data));
        check("a_parity_err", 32'(if_a.parity_err), 32'(ea.perr));
        check("a_framing_err", 32'(if_a.framing_err), 32'(ea.ferr));
      end
      va_cyc.push_back(cyc);
    end
    prev_va = if_a.valid;
  end

  always @(negedge clk) begin
    if (if_b.valid) begin
      check("b_valid_one_cycle", 32'(prev_vb), 32'd0);
      if (qb.size() == 0) check("b_valid_expected", 32'(qb.size()), 32'd1);
      else begin
        eb = qb.pop_front();
        check("b_data_out", 32'(if_b.data_out), 32'(eb.data));
        check("b_parity_err", 32'(if_b.parity_err), 32'(eb.perr));
        check("b_framing_err", 32'(if_b.framing_err), 32'(eb.ferr));
      end
      vb_cyc.push_back(cyc);
    end
    prev_vb = if_b.valid;
  end

  // One sample on A, followed by gap strobe-less cycles with SI toggling.
  task automatic bit_a(input logic b, input int gap);
    if_a.SI     = b;
    if_a.bit_en = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < gap; g++) begin
      if_a.bit_en = 1'b0;
      if_a.SI     = ~if_a.SI;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) bit_a(1'b1, 0);
  endtask

  task automatic frame_a(input logic [7:0] d, input logic par, input logic stop,
                         input int gap, input logic exp_perr);
    exp_t e;
    e.data = d; e.perr = exp_perr; e.ferr = !stop;
    qa.push_back(e);
    start_cyc_a = cyc + 1;
    bit_a(1'b0, gap);
    for (int i = 0; i < 8; i++) bit_a(d[i], gap);
    bit_a(par, gap);
    bit_a(stop, gap);
  endtask

  task automatic bit_b(input logic b);
    if_b.SI     = b;
    if_b.bit_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic frame_b(input logic [7:0] d);
    exp_t e;
    e.data = d; e.perr = 1'b0; e.ferr = 1'b0;
    qb.push_back(e);
    bit_b(1'b0);
    for (int i = 0; i < 8; i++) bit_b(d[i]);
    bit_b(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_before;
    rst = 1'b1;
    if_a.SI = 1'b1; if_a.bit_en = 1'b0;
    if_b.SI = 1'b1; if_b.bit_en = 1'b0;
    #2;
    check("rst_data_out", 32'(if_a.data_out), 32'd0);
    check("rst_valid", 32'(if_a.valid), 32'd0);
    check("rst_parity_err", 32'(if_a.parity_err), 32'd0);
    check("rst_framing_err", 32'(if_a.framing_err), 32'd0);
    check("rst_busy", 32'(if_a.busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    if_b.bit_en = 1'b1;
    idle_a(2);

    // Reset mid-frame: start plus three data bits, then async reset.
    bit_a(1'b0, 0); bit_a(1'b0, 0); bit_a(1'b1, 0); bit_a(1'b0, 0);
    check("midframe_busy", 32'(if_a.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(if_a.busy), 32'd0);
    check("abort_valid", 32'(if_a.valid), 32'd0);
    check("abort_data_out", 32'(if_a.data_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_a(2);
    frame_a(8'h5A, 1'b0, 1'b1, 0, 1'b0);
    idle_a(3);

    // Nominal 0xA5 with bit_en every cycle, valid 10 samples after the start bit.
    frame_a(8'hA5, 1'b0, 1'b1, 0, 1'b0);
    idle_a(3);
    check("a5_latency", 32'(va_cyc[$] - start_cyc_a), 32'd10);

    // Parity error: 0x03 has even weight, so parity bit 1 is wrong.
    frame_a(8'h03, 1'b1, 1'b1, 0, 1'b1);
    idle_a(3);

    // Framing error followed by a held-low line.
    frame_a(8'hFF, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) bit_a(1'b0, 0);
    n_before = va_cyc.size();
    for (int i = 0; i < 17; i++) bit_a(1'b0, 0);
    check("break_busy", 32'(if_a.busy), 32'd1);
    check("break_no_valid", 32'(va_cyc.size()), 32'(n_before));
    check("break_ferr_held", 32'(if_a.framing_err), 32'd1);
    idle_a(1);
    check("break_exit_busy", 32'(if_a.busy), 32'd0);
    frame_a(8'h11, 1'b0, 1'b1, 0, 1'b0);
    idle_a(3);

    // Sparse strobe: one bit_en every 4th cycle, SI toggling in between.
    frame_a(8'h3C, 1'b0, 1'b1, 3, 1'b0);
    idle_a(4);
    check("sparse_data_held", 32'(if_a.data_out), 32'h3C);

    // Back-to-back frames on the no-parity instance.
    frame_b(8'h01);
    frame_b(8'h80);
    bit_b(1'b1); bit_b(1'b1); bit_b(1'b1);
    check("b2b_valid_count", 32'(vb_cyc.size()), 32'd2);
    if (vb_cyc.size() == 2) check("b2b_spacing", 32'(vb_cyc[1] - vb_cyc[0]), 32'd10);
    check("b_parity_err_stuck", 32'(if_b.parity_err), 32'd0);

    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
